hsst_rx_rst_seq_v1_0: RTL and testbench

HSST_RX_RST_SEQ_V1_0 -- requirements
Module: hsst_rx_rst_seq_v1_0

---
 rtl/hsst_rx_rst_seq_v1_0.sv | 138 +++++++++++++
 tb/tb_hsst_rx_rst_seq_v1_0.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hsst_rx_rst_seq_v1_0.sv
// HSST receive-side reset sequencer: PLL reset -> PLL lock -> PMA reset -> stable
// CDR lock -> PCS reset -> word alignment -> link up, with fault-driven fallbacks.
module hsst_rx_rst_seq_v1_0 #(
  parameter int PLL_RST_CYC     = 64,
  parameter int PMA_RST_CYC     = 64,
  parameter int PCS_RST_CYC     = 32,
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       sigdet,
  input  logic       cdr_lock,
  input  logic       word_align,
  input  logic       wtchdg_rst_n,
  output logic       pll_rst,
  output logic       rx_pma_rst,
  output logic       rx_pcs_rst,
  output logic       rx_done,
  output logic       wtchdg_clr,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLL_RST    = 3'd1,
    PLL_WAIT   = 3'd2,
    PMA_RST    = 3'd3,
    CDR_WAIT   = 3'd4,
    PCS_RST    = 3'd5,
    ALIGN_WAIT = 3'd6,
    DONE       = 3'd7
  } state_t;

  localparam logic [CNT_WIDTH-1:0] PLL_LAST  = CNT_WIDTH'(PLL_RST_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] PMA_LAST  = CNT_WIDTH'(PMA_RST_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] PCS_LAST  = CNT_WIDTH'(PCS_RST_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_STABLE_CYC - 1);

  // Two-stage synchronizers, packed as {pll_lock, sigdet, cdr_lock, word_align}.
  logic [3:0] meta_q;
  logic [3:0] sync_q;
  logic       pll_lock_s, sigdet_s, cdr_lock_s, word_align_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {pll_lock, sigdet, cdr_lock, word_align};
      sync_q <= meta_q;
    end
  end

  assign {pll_lock_s, sigdet_s, cdr_lock_s, word_align_s} = sync_q;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 lock_ok;
  logic                 pll_rst_q, rx_pma_rst_q, rx_pcs_rst_q, rx_done_q, wtchdg_clr_q;
  logic                 pll_rst_d, rx_pma_rst_d, rx_pcs_rst_d, rx_done_d, wtchdg_clr_d;

  assign lock_ok = sigdet_s & cdr_lock_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:       state_d = PLL_RST;
      PLL_RST: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PLL_LAST) state_d = PLL_WAIT;
      end
      PLL_WAIT:   if (pll_lock_s) state_d = PMA_RST;
      PMA_RST: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PMA_LAST) state_d = CDR_WAIT;
      end
      CDR_WAIT: begin
        if (!lock_ok)                cnt_d = '0;
        else if (cnt_q == LOCK_LAST) state_d = PCS_RST;
        else                         cnt_d = cnt_q + 1'b1;
      end
      PCS_RST: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == PCS_LAST) state_d = ALIGN_WAIT;
      end
      ALIGN_WAIT: if (word_align_s) state_d = DONE;
      DONE:       state_d = DONE;
      default:    state_d = IDLE;
    endcase

    // Fault fallbacks, highest priority first; they override the normal progression.
    if (state_q >= PMA_RST && !pll_lock_s)          state_d = PLL_RST;
    else if (state_q >= CDR_WAIT && !wtchdg_rst_n)  state_d = PMA_RST;
    else if (state_q >= PCS_RST && !lock_ok)        state_d = PMA_RST;

    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    pll_rst_d    = (state_d == IDLE) || (state_d == PLL_RST);
    rx_pma_rst_d = (state_d <= PMA_RST);
    rx_pcs_rst_d = (state_d != DONE);
    rx_done_d    = (state_d == DONE);
    wtchdg_clr_d = (state_d <= PMA_RST) || ((state_d == CDR_WAIT) && !meta_q[2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pll_rst_q    <= 1'b1;
      rx_pma_rst_q <= 1'b1;
      rx_pcs_rst_q <= 1'b1;
      rx_done_q    <= 1'b0;
      wtchdg_clr_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pll_rst_q    <= pll_rst_d;
      rx_pma_rst_q <= rx_pma_rst_d;
      rx_pcs_rst_q <= rx_pcs_rst_d;
      rx_done_q    <= rx_done_d;
      wtchdg_clr_q <= wtchdg_clr_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign rx_pma_rst = rx_pma_rst_q;
  assign rx_pcs_rst = rx_pcs_rst_q;
  assign rx_done    = rx_done_q;
  assign wtchdg_clr = wtchdg_clr_q;
  assign state      = state_q;

endmodule

// File: tb/tb_hsst_rx_rst_seq_v1_0.sv
// Directed bench for hsst_rx_rst_seq_v1_0: a nominal-path vector table plus
// hand-timed sequences for glitch, watchdog, PLL loss, coincident faults and mid-run reset.
module tb_hsst_rx_rst_seq_v1_0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b1;
  logic       sigdet = 1'b1;
  logic       cdr_lock = 1'b1;
  logic       word_align = 1'b1;
  logic       wtchdg_rst_n = 1'b1;
  logic       pll_rst, rx_pma_rst, rx_pcs_rst, rx_done, wtchdg_clr;
  logic [2:0] state;

  int n_pass = 0;
  int n_total = 0;

  // Expected output nibble order: {pll_rst, rx_pma_rst, rx_pcs_rst, rx_done, wtchdg_clr}
  localparam logic [4:0] O_RST   = 5'b11101;
  localparam logic [4:0] O_WAIT  = 5'b01101;
  localparam logic [4:0] O_LINK  = 5'b00100;
  localparam logic [4:0] O_CLR   = 5'b00101;
  localparam logic [4:0] O_DONE  = 5'b00010;

  typedef struct {
    int         adv;
    logic [4:0] ins;   // {pll_lock, sigdet, cdr_lock, word_align, wtchdg_rst_n}
    logic [2:0] st;
    logic [4:0] outs;
    string      name;
  } vec_t;

  vec_t nom[12];

  hsst_rx_rst_seq_v1_0 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .sigdet       (sigdet),
    .cdr_lock     (cdr_lock),
    .word_align   (word_align),
    .wtchdg_rst_n (wtchdg_rst_n),
    .pll_rst      (pll_rst),
    .rx_pma_rst   (rx_pma_rst),
    .rx_pcs_rst   (rx_pcs_rst),
    .rx_done      (rx_done),
    .wtchdg_clr   (wtchdg_clr),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] es, input logic [4:0] eo);
    logic [4:0] ao;
    ao = {pll_rst, rx_pma_rst, rx_pcs_rst, rx_done, wtchdg_clr};
    n_total++;
    if (state === es) n_pass++;
    else $display("FAIL %s state: got %0d expected %0d", name, state, es);
    n_total++;
    if (ao === eo) n_pass++;
    else $display("FAIL %s outputs: got %b expected %b", name, ao, eo);
  endtask

  task automatic set_ins(input logic [4:0] v);
    {pll_lock, sigdet, cdr_lock, word_align, wtchdg_rst_n} = v;
  endtask

  // Leaves the bench 1 ns after a posedge with rst_n just released; next edge is edge 1.
  task automatic do_reset(input logic [4:0] v);
    rst_n = 1'b0;
    set_ins(v);
    step(3);
    check("reset_hold", 3'd0, O_RST);
    rst_n = 1'b1;
  endtask

  task automatic run_nominal(input string tag);
    for (int i = 0; i < 12; i++) begin
      set_ins(nom[i].ins);
      step(nom[i].adv);
      check({tag, "_", nom[i].name}, nom[i].st, nom[i].outs);
    end
  endtask

  initial begin
    // Edge numbers in comments count posedges after reset release.
    nom[0]  = '{1,    5'b11111, 3'd1, O_RST,  "pll_rst_enter"};   // edge 1
    nom[1]  = '{63,   5'b11111, 3'd1, O_RST,  "pll_rst_last"};    // edge 64
    nom[2]  = '{1,    5'b11111, 3'd2, O_WAIT, "pll_wait"};        // edge 65
    nom[3]  = '{1,    5'b11111, 3'd3, O_WAIT, "pma_rst_enter"};   // edge 66
    nom[4]  = '{63,   5'b11111, 3'd3, O_WAIT, "pma_rst_last"};    // edge 129
    nom[5]  = '{1,    5'b11111, 3'd4, O_LINK, "cdr_wait_enter"};  // edge 130
    nom[6]  = '{1023, 5'b11111, 3'd4, O_LINK, "cdr_wait_last"};   // edge 1153
    nom[7]  = '{1,    5'b11111, 3'd5, O_LINK, "pcs_rst_enter"};   // edge 1154
    nom[8]  = '{31,   5'b11111, 3'd5, O_LINK, "pcs_rst_last"};    // edge 1185
    nom[9]  = '{1,    5'b11111, 3'd6, O_LINK, "align_wait"};      // edge 1186
    nom[10] = '{1,    5'b11111, 3'd7, O_DONE, "done"};            // edge 1187
    nom[11] = '{50,   5'b11111, 3'd7, O_DONE, "done_hold"};       // edge 1237

    // Nominal path
    do_reset(5'b11111);
    run_nominal("nom");

    // cdr_lock glitch at CDR_WAIT count 500
    do_reset(5'b11111);
    step(630);
    check("glitch_pre", 3'd4, O_LINK);
    cdr_lock = 1'b0;
    step(1);                            // edge 631
    cdr_lock = 1'b1;
    step(569);                          // edge 1200: nominal would have left CDR_WAIT
    check("glitch_still_cdr", 3'd4, O_LINK);
    step(456);                          // edge 1656
    check("glitch_cdr_last", 3'd4, O_LINK);
    step(1);                            // edge 1657
    check("glitch_pcs_enter", 3'd5, O_LINK);

    // Watchdog trip in ALIGN_WAIT, then sigdet drop in CDR_WAIT
    do_reset(5'b11101);
    step(1190);
    check("wd_align", 3'd6, O_LINK);
    wtchdg_rst_n = 1'b0;
    step(1);                            // edge 1191
    wtchdg_rst_n = 1'b1;
    check("wd_pma_enter", 3'd3, O_WAIT);
    step(63);                           // edge 1254
    check("wd_pma_last", 3'd3, O_WAIT);
    step(1);                            // edge 1255
    check("wd_cdr_enter", 3'd4, O_LINK);
    sigdet = 1'b0;
    step(1);
    check("sigdet_sync1", 3'd4, O_LINK);
    step(1);
    check("sigdet_clr", 3'd4, O_CLR);
    sigdet = 1'b1;

    // PLL loss in DONE
    do_reset(5'b11111);
    step(1190);
    check("pll_done", 3'd7, O_DONE);
    pll_lock = 1'b0;
    step(2);                            // edge 1192: still in sync pipeline
    check("pll_loss_sync", 3'd7, O_DONE);
    step(1);                            // edge 1193
    check("pll_loss_rst", 3'd1, O_RST);
    pll_lock = 1'b1;
    step(63);                           // edge 1256
    check("pll_loss_rst_last", 3'd1, O_RST);
    step(1);                            // edge 1257
    check("pll_loss_wait", 3'd2, O_WAIT);

    // Coincident faults as seen by the FSM: pll_lock_s, sigdet_s and wtchdg_rst_n low together
    do_reset(5'b11111);
    step(1190);
    pll_lock = 1'b0;
    sigdet = 1'b0;
    step(2);                            // edge 1192
    check("multi_pre", 3'd7, O_DONE);
    wtchdg_rst_n = 1'b0;
    step(1);                            // edge 1193
    check("multi_pll_wins", 3'd1, O_RST);
    set_ins(5'b11111);

    // Reset asserted mid-sequence in CDR_WAIT, then full rerun
    do_reset(5'b11111);
    step(300);
    check("mid_cdr", 3'd4, O_LINK);
    rst_n = 1'b0;
    #1;
    check("mid_async_rst", 3'd0, O_RST);
    do_reset(5'b11111);
    run_nominal("rerun");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
